// File: rtl/cube_pkg.sv
// Shared types and helpers for the LED cube scan engine.
package cube_pkg;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_LOAD,
    ST_SHOW
  } scan_state_e;

  function automatic int unsigned frame_bits(input int unsigned n);
    return n * n * n;
  endfunction

  function automatic int unsigned scan_ticks(input int unsigned n, input int unsigned bw);
    return n * (1 + n + (1 << bw));
  endfunction

  // Flat frame bit for (layer, row, col); a row's columns are contiguous.
  function automatic int unsigned cube_idx(input int unsigned n, input int unsigned layer,
                                           input int unsigned row, input int unsigned col);
    return layer * n * n + row * n + col;
  endfunction

  localparam int unsigned CUBE_N_DEF   = 8;
  localparam int unsigned BRIGHT_W_DEF = 4;
  localparam int unsigned FRAME_BITS   = frame_bits(CUBE_N_DEF);
  localparam int unsigned SCAN_TICKS   = scan_ticks(CUBE_N_DEF, BRIGHT_W_DEF);

endpackage

// File: rtl/cube_scan_engine_if.sv
// Frame-source side and cube-pin side of the scan engine in one bundle.
interface cube_scan_engine_if #(
  parameter int CUBE_N   = 8,
  parameter int BRIGHT_W = 4
);
  logic                     en;
  logic [CUBE_N**3-1:0]     frame_cube_flat;
  logic                     frame_valid;
  logic [BRIGHT_W-1:0]      brightness;
  logic [CUBE_N-1:0]        high_csn;
  logic [CUBE_N-1:0]        row;
  logic [CUBE_N-1:0]        row_cs;
  logic                     scan_done;
  logic [31:0]              frame_cnt;

  modport master (
    output en, frame_cube_flat, frame_valid, brightness,
    input  high_csn, row, row_cs, scan_done, frame_cnt
  );

  modport slave (
    input  en, frame_cube_flat, frame_valid, brightness,
    output high_csn, row, row_cs, scan_done, frame_cnt
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Scan tick strobe: one clk pulse every 2^DIV cycles (every cycle when DIV=0).
// Combinational tick from a registered counter; clr holds it silent and restarts the period.
module scan_tick_gen #(
  parameter int DIV = 14
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 0) ? DIV : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick = !clr && ((DIV == 0) || (&cnt_q));
endmodule

// File: rtl/cube_scan_engine.sv
// Double-buffered BLANK/LOAD/SHOW layer scanner with PWM brightness; outputs registered, one clk after a tick.
// No backpressure: frame_valid always lands in the shadow (latest wins) and swaps only at scan end.
module cube_scan_engine
  import cube_pkg::*;
#(
  parameter int CUBE_N       = 8,
  parameter int SCAN_CLK_DIV = 14,
  parameter int BRIGHT_W     = 4
) (
  input logic                clk,
  input logic                resetn,
  cube_scan_engine_if.slave  bus
);
  localparam int FB = int'(frame_bits(CUBE_N));
  localparam int LW = $clog2(CUBE_N);
  localparam int IW = $clog2(FB);

  scan_state_e          state_q, state_d;
  logic [LW-1:0]        l_q, l_d, r_q, r_d;
  logic [BRIGHT_W-1:0]  k_q, k_d, b_q, b_d;
  logic [FB-1:0]        shadow_q, shadow_d, active_q, active_d;
  logic                 pending_q, pending_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic [CUBE_N-1:0]    high_csn_q, high_csn_d, row_q, row_d, row_cs_q, row_cs_d;
  logic                 scan_done_q, scan_done_d;
  logic                 tick, swap;
  logic [IW-1:0]        row_base;

  scan_tick_gen #(.DIV(SCAN_CLK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!bus.en),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    k_d         = k_q;
    b_d         = b_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    scan_done_d = 1'b0;
    swap        = 1'b0;

    if (!bus.en) begin
      state_d = ST_BLANK;
      l_d     = '0;
      r_d     = '0;
      k_d     = '0;
    end else if (tick) begin
      case (state_q)
        ST_BLANK: begin
          state_d = ST_LOAD;
          r_d     = '0;
        end
        ST_LOAD: begin
          if (r_q == LW'(CUBE_N - 1)) begin
            state_d = ST_SHOW;
            k_d     = '0;
            b_d     = bus.brightness;
          end else begin
            r_d = r_q + LW'(1);
          end
        end
        ST_SHOW: begin
          if (&k_q) begin
            state_d = ST_BLANK;
            if (l_q == LW'(CUBE_N - 1)) begin
              l_d         = '0;
              scan_done_d = 1'b1;
              swap        = pending_q;
            end else begin
              l_d = l_q + LW'(1);
            end
          end else begin
            k_d = k_q + BRIGHT_W'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // Swap takes the old shadow; a coincident capture then refills it and re-arms pending.
    if (swap) begin
      active_d    = shadow_q;
      pending_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
    if (bus.en && bus.frame_valid) begin
      shadow_d  = bus.frame_cube_flat;
      pending_d = 1'b1;
    end

    high_csn_d = '1;
    row_cs_d   = '0;
    row_d      = '0;
    row_base   = IW'(cube_idx(CUBE_N, 32'(l_d), 32'(r_d), 0));
    case (state_d)
      ST_LOAD: begin
        row_cs_d[r_d] = 1'b1;
        row_d         = active_q[row_base +: CUBE_N];
      end
      ST_SHOW: high_csn_d[l_d] = !(k_d < b_d);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_BLANK;
      l_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      b_q         <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= '0;
      high_csn_q  <= '1;
      row_q       <= '0;
      row_cs_q    <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      k_q         <= k_d;
      b_q         <= b_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      high_csn_q  <= high_csn_d;
      row_q       <= row_d;
      row_cs_q    <= row_cs_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.high_csn  = high_csn_q;
  assign bus.row       = row_q;
  assign bus.row_cs    = row_cs_q;
  assign bus.scan_done = scan_done_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_cube_scan_engine.sv
// Directed bench for cube_scan_engine at N=4, DIV=0, BRIGHT_W=2 (36-tick scan).
module tb_cube_scan_engine;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cube_scan_engine_if #(.CUBE_N(4), .BRIGHT_W(2)) bus ();

  cube_scan_engine #(.CUBE_N(4), .SCAN_CLK_DIV(0), .BRIGHT_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  localparam logic [63:0] F1 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] FA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FB = 64'hF0F0_1234_5678_0FF0;
  localparam logic [63:0] FC = 64'h5A5A_A5A5_3C3C_C3C3;
  localparam logic [63:0] FD = 64'h1111_2222_4444_8888;
  localparam logic [63:0] FE = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] FZ = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected {high_csn, row_cs, row, scan_done} j cycles after a scan_done sample.
  function automatic logic [12:0] model(input logic [63:0] fr, input logic [1:0] br0,
                                        input logic [1:0] br1, input int j);
    int layer = (j / 9) % 4;
    int pos   = j % 9;
    logic [3:0] hc = 4'hF;
    logic [3:0] cs = 4'h0;
    logic [3:0] rw = 4'h0;
    logic [1:0] b  = (layer == 0) ? br0 : br1;
    if (pos >= 1 && pos <= 4) begin
      cs = 4'(1 << (pos - 1));
      rw = fr[layer*16 + (pos-1)*4 +: 4];
    end else if (pos >= 5) begin
      if ((pos - 5) < int'(b)) hc[layer] = 1'b0;
    end
    return {hc, cs, rw, (j == 36)};
  endfunction

  // Checks one full scan; optionally strobes one or two frames at its start.
  task automatic observe(input string tag, input logic [63:0] fr, input logic [1:0] br0,
                         input logic [1:0] br1, input int ns,
                         input logic [63:0] s1, input logic [63:0] s2);
    bus.brightness = br0;
    if (ns > 0) begin
      bus.frame_cube_flat = s1;
      bus.frame_valid     = 1'b1;
    end
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk);
      chk($sformatf("%s_j%0d", tag, j),
          64'({bus.high_csn, bus.row_cs, bus.row, bus.scan_done}),
          64'(model(fr, br0, br1, j)));
      if (j == 1) begin
        if (ns == 2) bus.frame_cube_flat = s2;
        else         bus.frame_valid     = 1'b0;
      end
      if (j == 2) bus.frame_valid = 1'b0;
      if (j == 6) bus.brightness = br1;
    end
  endtask

  initial begin
    resetn              = 1'b0;
    bus.en              = 1'b0;
    bus.frame_valid     = 1'b0;
    bus.frame_cube_flat = '0;
    bus.brightness      = 2'd0;
    exp_cnt             = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_hc",   64'(bus.high_csn),  64'hF);
    chk("rst_cs",   64'(bus.row_cs),    64'h0);
    chk("rst_row",  64'(bus.row),       64'h0);
    chk("rst_done", 64'(bus.scan_done), 64'h0);
    chk("rst_cnt",  64'(bus.frame_cnt), 64'h0);

    resetn = 1'b1;
    bus.en = 1'b1;
    observe("boot", '0, 2'd1, 2'd1, 0, '0, '0);
    chk("boot_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));

    // Single frame: corners of the cube.
    observe("s_old", '0, 2'd3, 2'd3, 1, F1, '0);
    exp_cnt++;
    chk("s_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
    observe("s_new", F1, 2'd3, 2'd3, 0, '0, '0);
    chk("s_cnt_hold", 64'(bus.frame_cnt), 64'(exp_cnt));

    // Overwrite: A then B before the swap, only B shown.
    observe("ow_old", F1, 2'd2, 2'd2, 2, FA, FB);
    exp_cnt++;
    chk("ow_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));
    observe("ow_new", FB, 2'd2, 2'd2, 0, '0, '0);

    // Brightness zero, then a change mid-window that waits for the next SHOW.
    observe("b0", FB, 2'd0, 2'd0, 0, '0, '0);
    observe("bmid", FB, 2'd0, 2'd3, 0, '0, '0);
    chk("b_cnt", 64'(bus.frame_cnt), 64'(exp_cnt));

    // Coincident strobe on the swap cycle.
    bus.brightness      = 2'd1;
    bus.frame_cube_flat = FC;
    bus.frame_valid     = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    repeat (34) @(negedge clk);
    bus.frame_cube_flat = FD;
    bus.frame_valid     = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    chk("co_done", 64'(bus.scan_done), 64'h1);
    exp_cnt++;
    chk("co_cnt1", 64'(bus.frame_cnt), 64'(exp_cnt));
    observe("co_c", FC, 2'd1, 2'd1, 0, '0, '0);
    exp_cnt++;
    chk("co_cnt2", 64'(bus.frame_cnt), 64'(exp_cnt));
    observe("co_d", FD, 2'd1, 2'd1, 0, '0, '0);
    chk("co_cnt3", 64'(bus.frame_cnt), 64'(exp_cnt));

    // Enable drop in layer 2 with a frame pending.
    bus.frame_cube_flat = FE;
    bus.frame_valid     = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    repeat (19) @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("en_idle1", 64'({bus.high_csn, bus.row_cs, bus.row, bus.scan_done}), 64'h1E00);
    chk("en_cnt1", 64'(bus.frame_cnt), 64'(exp_cnt));
    bus.frame_cube_flat = FZ;
    bus.frame_valid     = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_idle2", 64'({bus.high_csn, bus.row_cs, bus.row, bus.scan_done}), 64'h1E00);
    chk("en_cnt2", 64'(bus.frame_cnt), 64'(exp_cnt));
    bus.en = 1'b1;
    observe("en_re", FD, 2'd3, 2'd3, 0, '0, '0);
    exp_cnt++;
    chk("en_cnt3", 64'(bus.frame_cnt), 64'(exp_cnt));
    observe("en_e", FE, 2'd3, 2'd3, 0, '0, '0);

    // Reset asserted in the middle of layer 0 SHOW.
    repeat (5) @(negedge clk);
    chk("pre_rst_hc", 64'(bus.high_csn), 64'hE);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_hc",  64'(bus.high_csn),  64'hF);
    chk("mid_rst_cs",  64'(bus.row_cs),    64'h0);
    chk("mid_rst_cnt", 64'(bus.frame_cnt), 64'h0);
    resetn = 1'b1;
    observe("post_rst", '0, 2'd3, 2'd3, 0, '0, '0);
    chk("post_rst_cnt", 64'(bus.frame_cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
